// File: rtl/thresholder_direct_8ch_if.sv
// ---------------------------------------------------------------------------
// thresholder_direct_8ch_if
//   Bundles the eight transceiver RX channels feeding the thresholder and the
//   two results it hands to the DRAM write controller.
//
//   rx_syncstatus_0..7 [1:0]  : per-channel transceiver sync status (2'b11 = locked)
//   rx_datak_0..7      [1:0]  : per-channel control-character flags
//   RX_data_0..7       [15:0] : per-channel received word
//   triggering_time_stamp [15:0]     : frame timestamp of the current/last trigger
//   threshold_decision_to_DRAM_ctrl  : high while the post-trigger window runs
//
//   master : the RX side (drives channel words, observes the results)
//   slave  : the thresholder (consumes channel words, drives the results)
// ---------------------------------------------------------------------------
interface thresholder_direct_8ch_if;
  logic [1:0]  rx_syncstatus_0, rx_syncstatus_1, rx_syncstatus_2, rx_syncstatus_3;
  logic [1:0]  rx_syncstatus_4, rx_syncstatus_5, rx_syncstatus_6, rx_syncstatus_7;
  logic [1:0]  rx_datak_0, rx_datak_1, rx_datak_2, rx_datak_3;
  logic [1:0]  rx_datak_4, rx_datak_5, rx_datak_6, rx_datak_7;
  logic [15:0] RX_data_0, RX_data_1, RX_data_2, RX_data_3;
  logic [15:0] RX_data_4, RX_data_5, RX_data_6, RX_data_7;
  logic [15:0] triggering_time_stamp;
  logic        threshold_decision_to_DRAM_ctrl;

  modport master (
    output rx_syncstatus_0, rx_syncstatus_1, rx_syncstatus_2, rx_syncstatus_3,
           rx_syncstatus_4, rx_syncstatus_5, rx_syncstatus_6, rx_syncstatus_7,
           rx_datak_0, rx_datak_1, rx_datak_2, rx_datak_3,
           rx_datak_4, rx_datak_5, rx_datak_6, rx_datak_7,
           RX_data_0, RX_data_1, RX_data_2, RX_data_3,
           RX_data_4, RX_data_5, RX_data_6, RX_data_7,
    input  triggering_time_stamp, threshold_decision_to_DRAM_ctrl
  );

  modport slave (
    input  rx_syncstatus_0, rx_syncstatus_1, rx_syncstatus_2, rx_syncstatus_3,
           rx_syncstatus_4, rx_syncstatus_5, rx_syncstatus_6, rx_syncstatus_7,
           rx_datak_0, rx_datak_1, rx_datak_2, rx_datak_3,
           rx_datak_4, rx_datak_5, rx_datak_6, rx_datak_7,
           RX_data_0, RX_data_1, RX_data_2, RX_data_3,
           RX_data_4, RX_data_5, RX_data_6, RX_data_7,
    output triggering_time_stamp, threshold_decision_to_DRAM_ctrl
  );
endinterface

// File: rtl/thresholder_direct_8ch.sv
// ---------------------------------------------------------------------------
// thresholder_direct_8ch
//   Eight-channel direct-path threshold trigger. Every channel carries fixed
//   frames (start word, timestamp, samples, end word). Each channel is parsed
//   independently; any sample strictly above THRESHOLD opens a capture window
//   of POST_TRIGGER_ENDING cycles towards the DRAM controller and reports the
//   timestamp of the frame that caused it (lowest channel wins on ties).
//
//   rx_std_clkout : common clock for all channels
//   rst_n         : asynchronous reset, active HIGH despite its name
//   rx_if         : channel words in, decision/timestamp out (slave modport)
// ---------------------------------------------------------------------------
module thresholder_direct_8ch #(
  parameter logic [15:0] THRESHOLD           = 16'h7FFF,
  parameter logic [15:0] POST_TRIGGER_ENDING = 16'd500,
  parameter logic [15:0] START_WORD          = 16'hDEAD,
  parameter logic [15:0] END_WORD            = 16'h7FFF,
  parameter int          FRAME_LEN           = 128
) (
  input  logic                    rx_std_clkout,
  input  logic                    rst_n,
  thresholder_direct_8ch_if.slave rx_if
);
  localparam int NCH   = 8;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] FIRST_SAMPLE_IDX = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_IDX         = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, TSTAMP = 2'd1, DATA = 2'd2} state_t;

  // Counter reload: a zero-length window still gives one decision cycle.
  function automatic logic [15:0] window_load(input logic [15:0] len);
    window_load = (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

  logic [1:0]       sync_p0_d  [NCH];
  logic [1:0]       sync_p0_q  [NCH];
  logic [1:0]       datak_p0_d [NCH];
  logic [1:0]       datak_p0_q [NCH];
  logic [15:0]      data_p0_d  [NCH];
  logic [15:0]      data_p0_q  [NCH];
  logic [NCH-1:0]   vld_p0;
  state_t           state_d    [NCH];
  state_t           state_q    [NCH];
  logic [IDX_W-1:0] idx_d      [NCH];
  logic [IDX_W-1:0] idx_q      [NCH];
  logic [15:0]      frame_ts_d [NCH];
  logic [15:0]      frame_ts_q [NCH];
  logic [NCH-1:0]   ts_cap_p0;
  logic [NCH-1:0]   hit_p0;
  logic [15:0]      win_ts_p0;
  logic             dec_d, dec_q;
  logic [15:0]      cnt_d, cnt_q;
  logic [15:0]      trig_ts_d, trig_ts_q;

  // ---- stage p0: input registers --------------------------------------------
  always_comb begin
    sync_p0_d[0]  = rx_if.rx_syncstatus_0;  sync_p0_d[1]  = rx_if.rx_syncstatus_1;
    sync_p0_d[2]  = rx_if.rx_syncstatus_2;  sync_p0_d[3]  = rx_if.rx_syncstatus_3;
    sync_p0_d[4]  = rx_if.rx_syncstatus_4;  sync_p0_d[5]  = rx_if.rx_syncstatus_5;
    sync_p0_d[6]  = rx_if.rx_syncstatus_6;  sync_p0_d[7]  = rx_if.rx_syncstatus_7;
    datak_p0_d[0] = rx_if.rx_datak_0;       datak_p0_d[1] = rx_if.rx_datak_1;
    datak_p0_d[2] = rx_if.rx_datak_2;       datak_p0_d[3] = rx_if.rx_datak_3;
    datak_p0_d[4] = rx_if.rx_datak_4;       datak_p0_d[5] = rx_if.rx_datak_5;
    datak_p0_d[6] = rx_if.rx_datak_6;       datak_p0_d[7] = rx_if.rx_datak_7;
    data_p0_d[0]  = rx_if.RX_data_0;        data_p0_d[1]  = rx_if.RX_data_1;
    data_p0_d[2]  = rx_if.RX_data_2;        data_p0_d[3]  = rx_if.RX_data_3;
    data_p0_d[4]  = rx_if.RX_data_4;        data_p0_d[5]  = rx_if.RX_data_5;
    data_p0_d[6]  = rx_if.RX_data_6;        data_p0_d[7]  = rx_if.RX_data_7;
  end

  always_ff @(posedge rx_std_clkout or posedge rst_n) begin
    if (rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        sync_p0_q[ch]  <= 2'b00;
        datak_p0_q[ch] <= 2'b00;
        data_p0_q[ch]  <= 16'd0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        sync_p0_q[ch]  <= sync_p0_d[ch];
        datak_p0_q[ch] <= datak_p0_d[ch];
        data_p0_q[ch]  <= data_p0_d[ch];
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++)
      vld_p0[ch] = (sync_p0_q[ch] == 2'b11) && (datak_p0_q[ch] == 2'b00);
  end

  // ---- stage p0 -> p1: per-channel frame parsers ----------------------------
  always_ff @(posedge rx_std_clkout or posedge rst_n) begin
    if (rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= HUNT;
        idx_q[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        idx_q[ch]   <= idx_d[ch];
      end
    end
  end

  // Frame timestamps are only consumed after their TSTAMP word was seen.
  always_ff @(posedge rx_std_clkout) begin
    for (int ch = 0; ch < NCH; ch++)
      frame_ts_q[ch] <= frame_ts_d[ch];
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      idx_d[ch]   = idx_q[ch];
      if (sync_p0_q[ch] != 2'b11) begin
        state_d[ch] = HUNT;
      end else if (vld_p0[ch]) begin
        unique case (state_q[ch])
          HUNT:    if (data_p0_q[ch] == START_WORD) state_d[ch] = TSTAMP;
          TSTAMP: begin
            state_d[ch] = DATA;
            idx_d[ch]   = FIRST_SAMPLE_IDX;
          end
          DATA: begin
            // Good or bad end word, the parser re-hunts; a bad one simply
            // means the frame is dropped without further action.
            if (idx_q[ch] == LAST_IDX) state_d[ch] = HUNT;
            else                       idx_d[ch]   = idx_q[ch] + IDX_W'(1);
          end
          default: state_d[ch] = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      ts_cap_p0[ch]  = vld_p0[ch] && (state_q[ch] == TSTAMP);
      hit_p0[ch]     = vld_p0[ch] && (state_q[ch] == DATA) && (idx_q[ch] != LAST_IDX)
                       && (data_p0_q[ch] > THRESHOLD);
      frame_ts_d[ch] = ts_cap_p0[ch] ? data_p0_q[ch] : frame_ts_q[ch];
    end
  end

  // ---- stage p1: trigger decision and post-trigger window -------------------
  always_comb begin
    win_ts_p0 = 16'd0;
    for (int ch = NCH - 1; ch >= 0; ch--)
      if (hit_p0[ch]) win_ts_p0 = frame_ts_q[ch];

    dec_d     = dec_q;
    cnt_d     = cnt_q;
    trig_ts_d = trig_ts_q;
    if (!dec_q) begin
      if (|hit_p0) begin
        dec_d     = 1'b1;
        cnt_d     = window_load(POST_TRIGGER_ENDING);
        trig_ts_d = win_ts_p0;
      end
    end else if (cnt_q == 16'd0) begin
      dec_d = 1'b0;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge rx_std_clkout or posedge rst_n) begin
    if (rst_n) begin
      dec_q     <= 1'b0;
      cnt_q     <= 16'd0;
      trig_ts_q <= 16'd0;
    end else begin
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      trig_ts_q <= trig_ts_d;
    end
  end

  assign rx_if.threshold_decision_to_DRAM_ctrl = dec_q;
  assign rx_if.triggering_time_stamp           = trig_ts_q;
endmodule

// File: tb/tb_thresholder_direct_8ch.sv
module tb_thresholder_direct_8ch;
  localparam int PTE = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sync_a [8];
  logic [1:0]  dk_a   [8];
  logic [15:0] dat_a  [8];

  thresholder_direct_8ch_if bif ();

  assign bif.rx_syncstatus_0 = sync_a[0]; assign bif.rx_syncstatus_1 = sync_a[1];
  assign bif.rx_syncstatus_2 = sync_a[2]; assign bif.rx_syncstatus_3 = sync_a[3];
  assign bif.rx_syncstatus_4 = sync_a[4]; assign bif.rx_syncstatus_5 = sync_a[5];
  assign bif.rx_syncstatus_6 = sync_a[6]; assign bif.rx_syncstatus_7 = sync_a[7];
  assign bif.rx_datak_0 = dk_a[0]; assign bif.rx_datak_1 = dk_a[1];
  assign bif.rx_datak_2 = dk_a[2]; assign bif.rx_datak_3 = dk_a[3];
  assign bif.rx_datak_4 = dk_a[4]; assign bif.rx_datak_5 = dk_a[5];
  assign bif.rx_datak_6 = dk_a[6]; assign bif.rx_datak_7 = dk_a[7];
  assign bif.RX_data_0 = dat_a[0]; assign bif.RX_data_1 = dat_a[1];
  assign bif.RX_data_2 = dat_a[2]; assign bif.RX_data_3 = dat_a[3];
  assign bif.RX_data_4 = dat_a[4]; assign bif.RX_data_5 = dat_a[5];
  assign bif.RX_data_6 = dat_a[6]; assign bif.RX_data_7 = dat_a[7];

  thresholder_direct_8ch #(
    .THRESHOLD          (16'h7FFF),
    .POST_TRIGGER_ENDING(16'(PTE)),
    .START_WORD         (16'hDEAD),
    .END_WORD           (16'h7FFF),
    .FRAME_LEN          (128)
  ) dut (
    .rx_std_clkout(clk),
    .rst_n        (rst),
    .rx_if        (bif)
  );

  logic        dec;
  logic [15:0] ts;
  assign dec = bif.threshold_decision_to_DRAM_ctrl;
  assign ts  = bif.triggering_time_stamp;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model -----------------
  // Each channel is tracked by the position of the next expected word
  // (-1 = waiting for a start word); the window is tracked as remaining
  // high cycles.
  int          pos_m [8];
  logic [15:0] fts_m [8];
  int          high_left = 0;
  logic [15:0] exp_ts = 16'd0;
  logic        pend = 1'b0;
  logic [15:0] pend_ts = 16'd0;
  int          cyc = 0;
  logic        hist [4096];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < 8; c++) pos_m[c] = -1;
      high_left = 0;
      exp_ts    = 16'd0;
      pend      = 1'b0;
    end else begin
      if (high_left == 0) begin
        if (pend) begin
          high_left = PTE;
          exp_ts    = pend_ts;
        end
      end else begin
        high_left--;
      end
      pend = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (sync_a[c] != 2'b11) pos_m[c] = -1;
        else if (dk_a[c] == 2'b00) begin
          if (pos_m[c] < 0) begin
            if (dat_a[c] == 16'hDEAD) pos_m[c] = 1;
          end else if (pos_m[c] == 1) begin
            fts_m[c] = dat_a[c];
            pos_m[c] = 2;
          end else if (pos_m[c] <= 126) begin
            if (dat_a[c] > 16'h7FFF && !pend) begin
              pend    = 1'b1;
              pend_ts = fts_m[c];
            end
            pos_m[c]++;
          end else begin
            pos_m[c] = -1;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare -----------------
  initial forever begin
    @(negedge clk);
    if (cyc < 4096) hist[cyc] = dec;
    chk("decision", {31'd0, dec}, {31'd0, (high_left > 0)});
    chk("timestamp", {16'd0, ts}, {16'd0, exp_ts});
  end

  // ---------------- stimulus -----------------
  logic [15:0] cfg_ts   [8];
  logic [15:0] cfg_base [8];
  int          cfg_step [8];
  int          cfg_hot  [8];
  int          cfg_ins  [8];
  logic        cfg_drop [8];

  task automatic clear_cfg();
    for (int c = 0; c < 8; c++) begin
      cfg_ts[c] = 16'd0; cfg_base[c] = 16'd0; cfg_step[c] = 0;
      cfg_hot[c] = 1000; cfg_ins[c] = -1; cfg_drop[c] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int c = 0; c < 8; c++) begin
      sync_a[c] = 2'b00; dk_a[c] = 2'b11; dat_a[c] = 16'hFFFF;
    end
  endtask

  // Drives one frame on every channel in mask, in lockstep, one slot per cycle.
  // A channel may carry one inserted slot (sync drop or control word).
  task automatic run_frame(input logic [7:0] mask);
    for (int t = 0; t < 130; t++) begin
      for (int c = 0; c < 8; c++) begin
        int f;
        f = (cfg_ins[c] >= 0 && t > cfg_ins[c]) ? t - 1 : t;
        sync_a[c] = 2'b11; dk_a[c] = 2'b00;
        if (!mask[c]) begin
          sync_a[c] = 2'b00; dk_a[c] = 2'b11; dat_a[c] = 16'hFFFF;
        end else if (t == cfg_ins[c]) begin
          if (cfg_drop[c]) begin sync_a[c] = 2'b00; dat_a[c] = 16'h1234; end
          else begin dk_a[c] = 2'b01; dat_a[c] = 16'hFFFF; end
        end else if (f == 0) dat_a[c] = 16'hDEAD;
        else if (f == 1) dat_a[c] = cfg_ts[c];
        else if (f <= 126) begin
          if (f - 2 >= cfg_hot[c]) dat_a[c] = 16'h8000;
          else dat_a[c] = cfg_base[c] + 16'(cfg_step[c] * (f - 2));
        end else if (f == 127) dat_a[c] = 16'h7FFF;
        else begin dk_a[c] = 2'b11; dat_a[c] = 16'hFFFF; end
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic count_high(input int a, input int b, output int n);
    n = 0;
    for (int i = a; i <= b; i++) if (i < 4096 && hist[i] === 1'b1) n++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dec === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, dec}, 32'd0);
  endtask

  initial begin
    int k, s, n;
    idle_all();
    clear_cfg();
    repeat (4) @(negedge clk);
    chk("reset_dec", {31'd0, dec}, 32'd0);
    chk("reset_ts", {16'd0, ts}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_invalid_dec", {31'd0, dec}, 32'd0);
    chk("idle_invalid_ts", {16'd0, ts}, 32'd0);

    // Channel 0: every early sample above threshold.
    clear_cfg();
    cfg_ts[0] = 16'hFFF0; cfg_base[0] = 16'hFFF1; cfg_step[0] = 1;
    k = cyc + 3;
    run_frame(8'h01);
    chk("pre_trigger_low", {31'd0, hist[k]}, 32'd0);
    count_high(k + 1, k + PTE, n);
    chk("window_len", n, PTE);
    chk("window_end_low", {31'd0, hist[k + PTE + 1]}, 32'd0);
    chk("retrigger", {31'd0, hist[k + PTE + 2]}, 32'd1);
    chk("ts_ch0", {16'd0, ts}, 32'h0000FFF0);
    wait_idle();

    // Sub-threshold frame with an ignored control word carrying 0xFFFF.
    clear_cfg();
    cfg_ts[1] = 16'h0003; cfg_base[1] = 16'h0004; cfg_step[1] = 1; cfg_ins[1] = 30;
    s = cyc;
    run_frame(8'h02);
    count_high(s + 1, cyc, n);
    chk("low_frame_no_trig", n, 0);
    chk("low_frame_ts_kept", {16'd0, ts}, 32'h0000FFF0);

    // Header exceeds threshold, samples sit exactly at threshold.
    clear_cfg();
    cfg_ts[2] = 16'h9000; cfg_base[2] = 16'h7FFF; cfg_step[2] = 0;
    s = cyc;
    run_frame(8'h04);
    count_high(s + 1, cyc, n);
    chk("header_no_trig", n, 0);

    // Simultaneous hit on channels 2 and 5.
    clear_cfg();
    cfg_ts[2] = 16'h0100; cfg_base[2] = 16'h0001; cfg_hot[2] = 5;
    cfg_ts[5] = 16'h0200; cfg_base[5] = 16'h0001; cfg_hot[5] = 5;
    s = cyc;
    run_frame(8'h24);
    count_high(s + 1, cyc, n);
    chk("simul_trig", {31'd0, (n > 0)}, 32'd1);
    chk("simul_ts_lowest", {16'd0, ts}, 32'h00000100);
    wait_idle();

    // Sync drop mid-frame: later hot samples belong to no frame.
    clear_cfg();
    cfg_ts[3] = 16'h0ABC; cfg_base[3] = 16'h0010; cfg_ins[3] = 40; cfg_drop[3] = 1'b1;
    cfg_hot[3] = 50;
    s = cyc;
    run_frame(8'h08);
    count_high(s + 1, cyc, n);
    chk("sync_drop_no_trig", n, 0);
    chk("sync_drop_ts_kept", {16'd0, ts}, 32'h00000100);

    // Late hit, then async reset while the window is open.
    clear_cfg();
    cfg_ts[3] = 16'h0ABC; cfg_base[3] = 16'h0010; cfg_hot[3] = 120;
    run_frame(8'h08);
    chk("late_hit_high", {31'd0, dec}, 32'd1);
    chk("late_hit_ts", {16'd0, ts}, 32'h00000ABC);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dec", {31'd0, dec}, 32'd0);
    chk("async_rst_ts", {16'd0, ts}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_dec", {31'd0, dec}, 32'd0);

    // Operates normally after reset.
    clear_cfg();
    cfg_ts[4] = 16'h5555; cfg_base[4] = 16'h0020; cfg_hot[4] = 0;
    run_frame(8'h10);
    chk("post_rst_ts", {16'd0, ts}, 32'h00005555);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
